alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  request; sampled only while idle.
REQ-005 Port: ALU_control  input  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 0100 MUL, 0101 DIV.
REQ-006 Port: A  input  WIDTH  first operand; SUB/SLT/DIV use it as minuend/dividend.
REQ-007 Port: B  input  WIDTH  second operand; SUB/SLT/DIV use it as subtrahend/divisor.
REQ-008 Port: result  output  WIDTH  registered result, held until the next completion.
REQ-009 Port: zero  output  1  registered, (result == 0).
REQ-010 Port: busy  output  1  high whenever state != IDLE.
REQ-011 Port: done  output  1  single-cycle completion pulse.
REQ-012 Port: div_by_zero  output  1  registered with result; high only for DIV with B == 0.

Function
REQ-013 FSM states: IDLE, RUN, DONE. busy is high in RUN and DONE.
REQ-014 IDLE + start + single-cycle op (AND/OR/ADD/SUB/SLT/NOR/undefined code): compute, register result/zero/div_by_zero, -> DONE.
REQ-015 IDLE + start + MUL or DIV: latch A, B, op; clear 5-bit iteration counter; -> RUN.
REQ-016 RUN: one shift-add (MUL) or one restoring-division step (DIV) per cycle; at count == WIDTH-1, register result, -> DONE.
REQ-017 DONE: done = 1 for exactly one cycle; unconditional -> IDLE.
REQ-018 Latency: for a single-cycle op, done is high in the cycle after start is sampled; for MUL/DIV, done is high WIDTH+1 cycles after start is sampled.
REQ-019 start in RUN or DONE is ignored and not queued; A, B and ALU_control are don't-care outside the sampling cycle.
REQ-020 ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
REQ-021 SLT: result = 1 if signed A < signed B, else 0.
REQ-022 MUL: result = low WIDTH bits of A*B; identical for signed and unsigned interpretation.
REQ-023 DIV: signed quotient, truncated toward zero; computed on magnitudes, sign applied at completion.
REQ-024 DIV with B == 0: no iteration; result = all ones; div_by_zero = 1; complete as a single-cycle op (done in the following cycle).
REQ-025 DIV of the most-negative value by -1: result = most-negative value (wrap); div_by_zero = 0.
REQ-026 Undefined ALU_control code: result = 0, zero = 1, single-cycle completion.
REQ-027 div_by_zero is cleared on every completion other than REQ-024.

Reset
REQ-028 While rst_n = 0: state = IDLE, result = 0, zero = 1, busy = 0, done = 0, div_by_zero = 0, counter = 0.
REQ-029 A reset during RUN or DONE aborts the operation with no done pulse; a start may be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package alu_pkg: the eight ALU_control code constants, the FSM state enum, and the WIDTH default.
REQ-031 Sub-module alu_muldiv_iter: holds the iterative MUL/DIV datapath (accumulator, shift registers, counter); alu_exec holds the FSM and the single-cycle ops.

Verification
REQ-032 Reset scenario: assert rst_n = 0 mid-RUN of a MUL -> busy drops immediately, no done pulse, result = 0.
REQ-033 ADD scenario: A = 0xFFFFFFFF, B = 1 -> done in the next cycle, result = 0, zero = 1.
REQ-034 SLT scenario: A = 0x80000000, B = 1 -> result = 1.
REQ-035 MUL scenario: A = 0xFFFFFFFE (-2), B = 7 -> done 33 cycles after start, result = 0xFFFFFFF2; busy stays high throughout.
REQ-036 DIV scenarios, each with the required response:
- A = -7, B = 2 -> result = 0xFFFFFFFD (-3), 33-cycle latency.
- A = 5, B = 0 -> result = 0xFFFFFFFF, div_by_zero = 1, 1-cycle latency.
REQ-037 Back-to-back scenario: start held high continuously, ignored while busy:
- sequence: SUB(10,3), then NOR(0,0) as the next IDLE acceptance;
- required response: results 7, then 0xFFFFFFFF, each with one done pulse.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
//============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU execution unit: operation
//               codes, FSM state encoding and the default datapath width.
// Revision    : 1.0 - initial release
//============================================================================
package alu_pkg;

    localparam int c_default_width = 32;

    localparam logic [3:0] c_op_and = 4'b0000;
    localparam logic [3:0] c_op_or  = 4'b0001;
    localparam logic [3:0] c_op_add = 4'b0010;
    localparam logic [3:0] c_op_sub = 4'b0110;
    localparam logic [3:0] c_op_slt = 4'b0111;
    localparam logic [3:0] c_op_nor = 4'b1100;
    localparam logic [3:0] c_op_mul = 4'b0100;
    localparam logic [3:0] c_op_div = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
//============================================================================
// Module      : alu_muldiv_iter
// Description : Iterative multiply (shift-add) / divide (restoring) datapath.
//               One step per cycle while step is high; last flags the final
//               step and value presents the completed result in that cycle.
// Ports       : clk, rst_n      - clock, async active-low reset
//               load            - capture a, b, is_div and clear the counter
//               step            - perform one iteration
//               is_div          - 1 = signed divide, 0 = multiply
//               a, b            - operands (dividend/divisor for divide)
//               last            - this step is the final one
//               value           - result as it will be after this step
// Revision    : 1.0 - initial release
//============================================================================
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] value
);

    localparam int CW = $clog2(WIDTH);

    // MUL: r_opa = multiplicand (shifts left), r_opb = multiplier (shifts right)
    // DIV: r_opa = dividend shifting out / quotient shifting in,
    //      r_opb = divisor magnitude, r_acc = partial remainder
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_neg;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_rem_sub;
    logic             w_fits;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_q;

    always_comb begin
        w_abs_a   = a[WIDTH-1] ? (~a + 1'b1) : a;
        w_abs_b   = b[WIDTH-1] ? (~b + 1'b1) : b;
        w_mul_acc = r_opb[0] ? (r_acc + r_opa) : r_acc;
        w_rem_sh  = {r_acc, r_opa[WIDTH-1]};
        w_rem_sub = w_rem_sh - {1'b0, r_opb};
        w_fits    = (w_rem_sh >= {1'b0, r_opb});
        // A fitting remainder is below the divisor, so it fits in WIDTH bits
        w_div_rem = w_fits ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
        w_div_q   = {r_opa[WIDTH-2:0], w_fits};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
        end else if (load) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_is_div <= is_div;
            if (is_div) begin
                r_opa <= w_abs_a;
                r_opb <= w_abs_b;
                r_neg <= a[WIDTH-1] ^ b[WIDTH-1];
            end else begin
                r_opa <= a;
                r_opb <= b;
                r_neg <= 1'b0;
            end
        end else if (step) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_is_div) begin
                r_acc <= w_div_rem;
                r_opa <= w_div_q;
            end else begin
                r_acc <= w_mul_acc;
                r_opa <= r_opa << 1;
                r_opb <= r_opb >> 1;
            end
        end
    end

    // Sign is applied to the quotient magnitude only at completion; the
    // most-negative / -1 case wraps naturally through the two's complement.
    always_comb begin
        last  = step && (r_cnt == CW'(WIDTH - 1));
        value = w_mul_acc;
        if (r_is_div) begin
            value = r_neg ? (~w_div_q + 1'b1) : w_div_q;
        end
    end

endmodule : alu_muldiv_iter
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
//============================================================================
// Module      : alu_exec
// Description : ALU execution unit. Logic/add/sub/slt/nor complete in one
//               cycle; MUL and DIV iterate for WIDTH cycles in a sub-module.
// Ports       : clk, rst_n      - clock, async active-low reset
//               start           - request, sampled only while idle
//               ALU_control     - operation code
//               A, B            - operands
//               result, zero    - registered result and (result == 0)
//               busy            - unit not idle
//               done            - one-cycle completion pulse
//               div_by_zero     - DIV with B == 0 completed
// Revision    : 1.0 - initial release
//============================================================================
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    alu_state_t       r_state;
    alu_state_t       w_state_next;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_dbz;

    logic [WIDTH-1:0] w_single_res;
    logic             w_single_dbz;
    logic             w_is_iter;
    logic             w_accept;
    logic             w_iter_load;
    logic             w_iter_step;
    logic             w_iter_last;
    logic [WIDTH-1:0] w_iter_val;

    // Single-cycle operations; a DIV by zero also completes here.
    always_comb begin
        w_single_res = '0;
        w_single_dbz = 1'b0;
        case (ALU_control)
            c_op_and: w_single_res = A & B;
            c_op_or:  w_single_res = A | B;
            c_op_add: w_single_res = A + B;
            c_op_sub: w_single_res = A - B;
            c_op_slt: w_single_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            c_op_nor: w_single_res = ~(A | B);
            c_op_div: begin
                w_single_res = '1;
                w_single_dbz = 1'b1;
            end
            default:  w_single_res = '0;
        endcase
    end

    assign w_is_iter   = (ALU_control == c_op_mul) ||
                         ((ALU_control == c_op_div) && (B != '0));
    assign w_accept    = (r_state == ST_IDLE) && start;
    assign w_iter_load = w_accept && w_is_iter;
    assign w_iter_step = (r_state == ST_RUN);

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_iter_load),
        .step   (w_iter_step),
        .is_div (ALU_control == c_op_div),
        .a      (A),
        .b      (B),
        .last   (w_iter_last),
        .value  (w_iter_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = w_is_iter ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_iter_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_dbz    <= 1'b0;
        end else if (w_accept && !w_is_iter) begin
            r_result <= w_single_res;
            r_zero   <= (w_single_res == '0);
            r_dbz    <= w_single_dbz;
        end else if (w_iter_last) begin
            r_result <= w_iter_val;
            r_zero   <= (w_iter_val == '0);
            r_dbz    <= 1'b0;
        end
    end

    assign result      = r_result;
    assign zero        = r_zero;
    assign div_by_zero = r_dbz;

endmodule : alu_exec
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
//============================================================================
// Module      : tb_alu_exec
// Description : Directed self-checking bench for alu_exec (WIDTH = 32).
// Revision    : 1.0 - initial release
//============================================================================
module tb_alu_exec;

    localparam logic [3:0] c_and = 4'b0000;
    localparam logic [3:0] c_or  = 4'b0001;
    localparam logic [3:0] c_add = 4'b0010;
    localparam logic [3:0] c_sub = 4'b0110;
    localparam logic [3:0] c_slt = 4'b0111;
    localparam logic [3:0] c_nor = 4'b1100;
    localparam logic [3:0] c_mul = 4'b0100;
    localparam logic [3:0] c_div = 4'b0101;
    localparam logic [3:0] c_bad = 4'b1111;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  ALU_control;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    alu_exec #(
        .WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ALU_control (ALU_control),
        .A           (A),
        .B           (B),
        .result      (result),
        .zero        (zero),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one operation, wait for done (bounded), then check outputs,
    // latency, busy during iteration and the one-cycle width of done.
    task automatic do_op(input string name, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_zero,
                         input logic exp_dbz, input int exp_lat, input bit hold);
        int lat;
        bit busy_ok;
        @(negedge clk);
        ALU_control = op;
        A           = a;
        B           = b;
        start       = 1'b1;
        @(posedge clk);
        #1;
        if (hold) begin
            // Keep requesting a different op; it must not be taken while busy
            ALU_control = c_add;
            A           = 32'd1;
            B           = 32'd1;
        end else begin
            start = 1'b0;
        end
        lat     = 1;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check_val({name, " result"}, result, exp_res);
        check_val({name, " zero"}, {31'd0, zero}, {31'd0, exp_zero});
        check_val({name, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
        check_val({name, " latency"}, lat, exp_lat);
        if (exp_lat > 1) check_val({name, " busy held"}, {31'd0, busy_ok}, 32'd1);
        @(posedge clk);
        #1;
        check_val({name, " done width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_seen;
        rst_n       = 1'b0;
        start       = 1'b0;
        ALU_control = c_and;
        A           = '0;
        B           = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset result", result, 32'd0);
        check_val("reset zero", {31'd0, zero}, 32'd1);
        check_val("reset busy", {31'd0, busy}, 32'd0);
        check_val("reset done", {31'd0, done}, 32'd0);
        check_val("reset dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("add wrap", c_add, 32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 1'b1, 1'b0, 1,  1'b0);
        do_op("slt neg",  c_slt, 32'h8000_0000, 32'd1,        32'h0000_0001, 1'b0, 1'b0, 1,  1'b0);
        do_op("and",      c_and, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 1,  1'b0);
        do_op("or",       c_or,  32'hF000_0001, 32'h0000_1000, 32'hF000_1001, 1'b0, 1'b0, 1,  1'b0);
        do_op("undef",    c_bad, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b1, 1'b0, 1,  1'b0);
        do_op("slt pos",  c_slt, 32'd5,         32'hFFFF_FFFD, 32'h0000_0000, 1'b1, 1'b0, 1,  1'b0);
        do_op("mul neg",  c_mul, 32'hFFFF_FFFE, 32'd7,        32'hFFFF_FFF2, 1'b0, 1'b0, 33, 1'b0);
        do_op("mul pos",  c_mul, 32'd123,       32'd456,      32'h0000_DB18, 1'b0, 1'b0, 33, 1'b0);
        do_op("div neg",  c_div, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0, 1'b0, 33, 1'b0);
        do_op("div zero", c_div, 32'd5,         32'd0,        32'hFFFF_FFFF, 1'b0, 1'b1, 1,  1'b0);
        do_op("div hold", c_div, 32'd100,       32'd7,        32'h0000_000E, 1'b0, 1'b0, 33, 1'b1);
        do_op("div min",  c_div, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 33, 1'b0);
        do_op("div negb", c_div, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0, 33, 1'b0);

        // Back-to-back with start held high throughout
        @(negedge clk);
        ALU_control = c_sub;
        A           = 32'd10;
        B           = 32'd3;
        start       = 1'b1;
        @(posedge clk);
        #1;
        check_val("b2b sub done", {31'd0, done}, 32'd1);
        check_val("b2b sub result", result, 32'd7);
        ALU_control = c_nor;
        A           = 32'd0;
        B           = 32'd0;
        @(posedge clk);
        #1;
        check_val("b2b gap done", {31'd0, done}, 32'd0);
        check_val("b2b gap result", result, 32'd7);
        @(posedge clk);
        #1;
        check_val("b2b nor done", {31'd0, done}, 32'd1);
        check_val("b2b nor result", result, 32'hFFFF_FFFF);
        start = 1'b0;
        @(posedge clk);
        #1;
        check_val("b2b nor done width", {31'd0, done}, 32'd0);

        // Reset in the middle of a multiply
        @(negedge clk);
        ALU_control = c_mul;
        A           = 32'd9;
        B           = 32'd9;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("rst mid busy", {31'd0, busy}, 32'd0);
        check_val("rst mid result", result, 32'd0);
        check_val("rst mid zero", {31'd0, zero}, 32'd1);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check_val("rst mid no done", done_seen, 32'd0);

        // A start presented on the first edge after release is accepted
        @(negedge clk);
        rst_n       = 1'b1;
        ALU_control = c_add;
        A           = 32'd20;
        B           = 32'd22;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val("post rst done", {31'd0, done}, 32'd1);
        check_val("post rst result", result, 32'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu_exec
`default_nettype wire
